// File: rtl/serial_subtractor_4bit.sv
// Bit-serial A - B over packed operands {A,B}: one full-subtractor cell plus a borrow flop, LSB first.
// Build option SERIAL_SUB_SAT_EN: clamp diff to 0 when the final borrow is set.
module serial_subtractor_4bit #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   diff,
  output logic               borrow
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               bin_q, bin_d;
  logic               in_ready_d, out_valid_d, borrow_d;
  logic [WIDTH-1:0]   diff_d;
  logic               d_bit_c, bout_c;
  logic [WIDTH-1:0]   res_next_c;

  // Full-subtractor cell on the current LSBs.
  always_comb begin
    d_bit_c    = a_q[0] ^ b_q[0] ^ bin_q;
    bout_c     = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & bin_q);
    res_next_c = {d_bit_c, res_q[WIDTH-1:1]};
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    cnt_d       = cnt_q;
    bin_d       = bin_q;
    in_ready_d  = in_ready;
    out_valid_d = out_valid;
    diff_d      = diff;
    borrow_d    = borrow;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          a_d        = in_data[2*WIDTH-1:WIDTH];
          b_d        = in_data[WIDTH-1:0];
          bin_d      = 1'b0;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        res_d = res_next_c;
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        bin_d = bout_c;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          borrow_d    = bout_c;
`ifdef SERIAL_SUB_SAT_EN
          diff_d      = bout_c ? '0 : res_next_c;
`else
          diff_d      = res_next_c;
`endif
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      cnt_q     <= '0;
      bin_q     <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      diff      <= '0;
      borrow    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      res_q     <= res_d;
      cnt_q     <= cnt_d;
      bin_q     <= bin_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      diff      <= diff_d;
      borrow    <= borrow_d;
    end
  end

endmodule

// File: tb/tb_serial_subtractor_4bit.sv
// Directed bench for serial_subtractor_4bit; expectations follow SERIAL_SUB_SAT_EN when defined.
module tb_serial_subtractor_4bit;

  localparam int unsigned WIDTH = 4;
`ifdef SERIAL_SUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  int checks = 0;
  int errors = 0;

  serial_subtractor_4bit #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for in_ready, then present data for exactly the accept edge.
  task automatic send(input string tag, input logic [7:0] data, input bit hold);
    int n = 0;
    while (!in_ready && n < 30) begin
      tick();
      n++;
    end
    chk({tag, "_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = data;
    tick();
    if (!hold) in_valid = 1'b0;
  endtask

  // Edges after the accept edge until out_valid is seen (21 means timeout).
  task automatic wait_result(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!out_valid && n < 21);
  endtask

  task automatic op(input string tag, input logic [7:0] data,
                    input logic [3:0] ed, input logic eb, input bit hold);
    int n;
    send(tag, data, hold);
    wait_result(n);
    chk({tag, "_latency"}, 32'(n), 32'd4);
    chk({tag, "_diff"}, 32'(diff), 32'(ed));
    chk({tag, "_borrow"}, 32'(borrow), 32'(eb));
    tick();
    chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    chk({tag, "_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int  n;
    bit  seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_borrow", 32'(borrow), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // 9 - 3 with out_ready held high throughout
    out_ready = 1'b1;
    op("basic", 8'b1001_0011, 4'b0110, 1'b0, 1'b0);

    // Reset in the middle of SHIFT: async clear, no result afterwards
    send("midrst", 8'b1001_0011, 1'b0);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_diff", 32'(diff), 32'd0);
    chk("midrst_borrow", 32'(borrow), 32'd0);
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    chk("midrst_no_result", 32'(seen), 32'd0);

    op("wrap", 8'b0000_1111, SAT ? 4'b0000 : 4'b0001, 1'b1, 1'b0);
    op("equal", 8'b1010_1010, 4'b0000, 1'b0, 1'b0);

    // Back-pressure: result held for 10 cycles, second operand refused
    out_ready = 1'b0;
    send("bp", 8'b1111_0001, 1'b0);
    wait_result(n);
    chk("bp_latency", 32'(n), 32'd4);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        in_valid = 1'b1;
        in_data  = 8'b1111_0001;
      end else begin
        in_valid = 1'b0;
      end
      if (diff !== 4'b1110 || in_ready !== 1'b0 || out_valid !== 1'b1) seen = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    chk("bp_held_stable", 32'(seen), 32'd0);
    chk("bp_diff", 32'(diff), 32'hE);
    out_ready = 1'b1;
    tick();
    chk("bp_valid_drop", 32'(out_valid), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (in_ready !== 1'b1 || out_valid !== 1'b0) seen = 1'b1;
      tick();
    end
    chk("bp_not_accepted", 32'(seen), 32'd0);

    // Back-to-back stream with in_valid held high
    op("s0", 8'b0101_0010, 4'b0011, 1'b0, 1'b1);
    op("s1", 8'b1000_1001, SAT ? 4'b0000 : 4'b1111, 1'b1, 1'b1);
    op("s2", 8'b1111_1111, 4'b0000, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
